// File: rtl/gpio_expander.sv
// SPI-slave GPIO expander: NUM_BANKS x 8 pins with direction, output, input and edge-interrupt registers.
// All asynchronous inputs are resynchronised into clk; SPI is mode 0, MSB first.
module gpio_expander #(
  parameter int unsigned NUM_BANKS = 2,
  parameter logic [7:0]  ID_VALUE  = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spi_sck,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  input  logic [8*NUM_BANKS-1:0] gpio_in,
  output logic [8*NUM_BANKS-1:0] gpio_out,
  output logic [8*NUM_BANKS-1:0] gpio_oe,
  output logic                   irq_n
);

  localparam int unsigned PW = 8 * NUM_BANKS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]    sck_sync, cs_sync, mosi_sync;
  logic          sck_prev, cs_prev;
  logic [PW-1:0] pin_s1, pin_s2, pin_prev;
  logic [2:0]    hist_vld;

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sh;
  logic [7:0]    miso_sh;
  logic          rw_q;
  logic [6:0]    ptr_q;

  logic          gie_q, gie_d;
  logic [PW-1:0] dir_q, dir_d, out_q, out_d, rise_q, rise_d, fall_q, fall_d;
  logic [PW-1:0] stat_q, stat_d, stat_clr;

  logic          sck_s, cs_s, sck_rise, sck_fall, cs_fall;
  logic          active, byte_done, wr_en, load_en;
  logic [7:0]    rx_byte, rd_data;
  logic [6:0]    rd_addr;
  logic [PW-1:0] rise_evt, fall_evt;

  // CS_N history resets low so a frame already running at reset never looks like a fresh start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
      pin_s1    <= '0;
      pin_s2    <= '0;
      pin_prev  <= '0;
      hist_vld  <= 3'b000;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_prev  <= sck_sync[1];
      cs_prev   <= cs_sync[1];
      pin_s1    <= gpio_in;
      pin_s2    <= pin_s1;
      pin_prev  <= pin_s2;
      hist_vld  <= {hist_vld[1:0], 1'b1};
    end
  end

  assign sck_s    = sck_sync[1];
  assign cs_s     = cs_sync[1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_fall  = cs_prev & ~cs_s;

  // Edge events only once pin_prev holds a genuinely synchronised sample.
  assign rise_evt = pin_s2 & ~pin_prev & {PW{hist_vld[2]}};
  assign fall_evt = ~pin_s2 & pin_prev & {PW{hist_vld[2]}};

  assign active    = ((state_q == ST_CMD) || (state_q == ST_DATA)) && !cs_s;
  assign byte_done = active && sck_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sh, mosi_sync[1]};
  assign wr_en     = byte_done && (state_q == ST_DATA) && !rw_q;
  assign rd_addr   = (state_q == ST_CMD) ? rx_byte[6:0] : ptr_q + 7'd1;
  assign load_en   = byte_done && ((state_q == ST_CMD) ? rx_byte[7] : rw_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD:  if (byte_done) state_d = ST_DATA;
        ST_DATA: state_d = ST_DATA;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shift engine; the falling edge right after a load is skipped so the loaded MSB stays on MISO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      rx_sh   <= 7'd0;
      miso_sh <= 8'h00;
      rw_q    <= 1'b0;
      ptr_q   <= 7'd0;
    end else if (!active) begin
      bit_cnt <= 3'd0;
      miso_sh <= 8'h00;
    end else begin
      if (sck_rise) begin
        rx_sh   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        if (state_q == ST_CMD) begin
          rw_q  <= rx_byte[7];
          ptr_q <= rx_byte[6:0];
        end else begin
          ptr_q <= ptr_q + 7'd1;
        end
        miso_sh <= load_en ? rd_data : 8'h00;
      end else if (sck_fall && (bit_cnt != 3'd0) && (state_q == ST_DATA)) begin
        miso_sh <= {miso_sh[6:0], 1'b0};
      end
    end
  end

  assign spi_miso = miso_sh[7];

  // Register read mux; anything not decoded reads as zero.
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      7'h00:   rd_data = ID_VALUE;
      7'h01:   rd_data = 8'(NUM_BANKS);
      7'h02:   rd_data = {7'd0, gie_q};
      default: begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          if (rd_addr[6:3] == 4'(b + 2)) begin
            case (rd_addr[2:0])
              3'd0:    rd_data = dir_q[b*8 +: 8];
              3'd1:    rd_data = out_q[b*8 +: 8];
              3'd2:    rd_data = pin_s2[b*8 +: 8];
              3'd3:    rd_data = rise_q[b*8 +: 8];
              3'd4:    rd_data = fall_q[b*8 +: 8];
              3'd5:    rd_data = stat_q[b*8 +: 8];
              default: rd_data = 8'h00;
            endcase
          end
        end
      end
    endcase
  end

  // Register write decode; IRQ_STAT set beats a same-cycle write-1-to-clear.
  always_comb begin
    gie_d    = gie_q;
    dir_d    = dir_q;
    out_d    = out_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    stat_clr = '0;
    if (wr_en) begin
      if (ptr_q == 7'h02) gie_d = rx_byte[0];
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (ptr_q[6:3] == 4'(b + 2)) begin
          case (ptr_q[2:0])
            3'd0:    dir_d[b*8 +: 8]    = rx_byte;
            3'd1:    out_d[b*8 +: 8]    = rx_byte;
            3'd3:    rise_d[b*8 +: 8]   = rx_byte;
            3'd4:    fall_d[b*8 +: 8]   = rx_byte;
            3'd5:    stat_clr[b*8 +: 8] = rx_byte;
            default: ;
          endcase
        end
      end
    end
    stat_d = (stat_q & ~stat_clr) | (rise_evt & rise_q) | (fall_evt & fall_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gie_q  <= 1'b0;
      dir_q  <= '0;
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
      irq_n  <= 1'b1;
    end else begin
      gie_q  <= gie_d;
      dir_q  <= dir_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      stat_q <= stat_d;
      irq_n  <= ~(gie_q & (|stat_q));
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

endmodule
